// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: FSM encoding, fun3 decodes,
// fault codes and the unshifted byte masks issued by the control unit.
package lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_FAULT = 3'd4
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // size is fun3[1:0]: 00 byte, 01 half, 10 word
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (size)
         2'b01:   mis = off[0];
         2'b10:   mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store lane shift, byte enables, alignment
// check for the incoming request, and load extraction/extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  req_size_i,
   input  logic [3:0]  req_mask_i,
   input  logic [1:0]  req_off_i,
   input  logic [31:0] req_wdata_i,
   output logic [3:0]  req_be_o,
   output logic [31:0] req_wdata_o,
   output logic        req_misalign_o,
   input  logic [2:0]  ld_fun3_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   logic [7:0]  be_wide;
   logic [31:0] ld_shift;

   always_comb begin
      be_wide        = {4'b0000, req_mask_i} << req_off_i;
      req_be_o       = be_wide[3:0];
      req_wdata_o    = req_wdata_i << {req_off_i, 3'b000};
      req_misalign_o = is_misaligned(req_size_i, req_off_i);
   end

   always_comb begin
      ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};
      case (ld_fun3_i)
         F3_LB:   ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
         F3_LH:   ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
         F3_LBU:  ld_data_o = {24'h000000, ld_shift[7:0]};
         F3_LHU:  ld_data_o = {16'h0000, ld_shift[15:0]};
         default: ld_data_o = ld_shift;
      endcase
   end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: captures one access from the control stage,
// runs the req/gnt/rvalid handshake and stalls the pipeline until it completes.
module lsu_sequencer
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        store,
   input  logic [2:0]  fun3,
   input  logic [3:0]  mem_mask,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_e       state_q, state_d;
   logic             op_load_q, op_load_d;
   logic [2:0]       fun3_q, fun3_d;
   logic [1:0]       off_q, off_d;
   logic [29:0]      waddr_q, waddr_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      ld_data_q, ld_data_d;
   logic [1:0]       code_q, code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             req_any;
   logic             misalign;
   logic             cnt_expired;
   logic             in_req;
   logic [3:0]       be_in;
   logic [31:0]      wdata_sh;
   logic [31:0]      ld_ext;

   lsu_align u_align (
      .req_size_i     (fun3[1:0]),
      .req_mask_i     (mem_mask),
      .req_off_i      (addr[1:0]),
      .req_wdata_i    (wdata),
      .req_be_o       (be_in),
      .req_wdata_o    (wdata_sh),
      .req_misalign_o (misalign),
      .ld_fun3_i      (fun3_q),
      .ld_off_i       (off_q),
      .ld_rdata_i     (dmem_rdata),
      .ld_data_o      (ld_ext)
   );

   assign req_any     = load | store;
   // >= rather than == so a gnt on the last REQ cycle still times out the following WAIT
   assign cnt_expired = (cnt_q >= CNT_LAST);

   always_comb begin
      state_d   = state_q;
      op_load_d = op_load_q;
      fun3_d    = fun3_q;
      off_d     = off_q;
      waddr_d   = waddr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      ld_data_d = ld_data_q;
      code_d    = code_q;
      cnt_d     = cnt_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (req_any) begin
               op_load_d = load;
               fun3_d    = fun3;
               off_d     = addr[1:0];
               waddr_d   = addr[31:2];
               be_d      = be_in;
               wdata_d   = wdata_sh;
               if (misalign) begin
                  state_d = ST_FAULT;
                  code_d  = FAULT_MISALIGN;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dmem_gnt) begin
               state_d = op_load_q ? ST_WAIT : ST_DONE;
            end else if (cnt_expired) begin
               state_d = ST_FAULT;
               code_d  = FAULT_TIMEOUT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dmem_rvalid) begin
               ld_data_d = ld_ext;
               state_d   = ST_DONE;
            end else if (cnt_expired) begin
               state_d = ST_FAULT;
               code_d  = FAULT_TIMEOUT;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_FAULT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_load_q <= 1'b0;
         fun3_q    <= '0;
         off_q     <= '0;
         waddr_q   <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         ld_data_q <= '0;
         code_q    <= FAULT_NONE;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_load_q <= op_load_d;
         fun3_q    <= fun3_d;
         off_q     <= off_d;
         waddr_q   <= waddr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         ld_data_q <= ld_data_d;
         code_q    <= code_d;
         cnt_q     <= cnt_d;
      end
   end

   // Bus outputs are only driven while a request is outstanding
   assign in_req     = (state_q == ST_REQ);
   assign dmem_req   = in_req;
   assign dmem_we    = in_req & ~op_load_q;
   assign dmem_be    = in_req ? be_q : '0;
   assign dmem_addr  = in_req ? {waddr_q, 2'b00} : '0;
   assign dmem_wdata = in_req ? wdata_q : '0;

   assign stall      = (state_q == ST_IDLE) ? req_any
                                            : (in_req || (state_q == ST_WAIT));
   assign ld_valid   = (state_q == ST_DONE) & op_load_q;
   assign ld_data    = ld_data_q;
   assign fault      = (state_q == ST_FAULT);
   assign fault_code = fault ? code_q : FAULT_NONE;

endmodule
